// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the transmitter, the receiver and the frame counter.
package i2s_pkg;

  localparam logic WS_LEFT   = 1'b0;
  localparam logic WS_RIGHT  = 1'b1;
  localparam logic ALIGN_I2S = 1'b0;
  localparam logic ALIGN_LJ  = 1'b1;

  localparam int unsigned DEF_DW   = 16;
  localparam int unsigned DEF_SLOT = 16;

endpackage

// File: rtl/i2s_frame_ctr.sv
// Frame position counter for an I2S bus: counts 0..2*SLOT-1 and drives word select.
module i2s_frame_ctr
  import i2s_pkg::*;
#(
  parameter int unsigned SLOT = DEF_SLOT
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [$clog2(2*SLOT)-1:0]      cnt,
  output logic                           wrap_c,
  output logic                           ws
);

  localparam int unsigned FRAME = 2 * SLOT;
  localparam int unsigned CW    = $clog2(FRAME);

  logic [CW-1:0] cnt_nxt;

  always_comb begin
    wrap_c  = (cnt == CW'(FRAME - 1));
    cnt_nxt = wrap_c ? '0 : cnt + CW'(1);
  end

  // ws is registered from the next count so it changes only at slot starts
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ws  <= WS_LEFT;
    end else begin
      cnt <= cnt_nxt;
      ws  <= (cnt_nxt >= CW'(SLOT)) ? WS_RIGHT : WS_LEFT;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter with a one-deep sample buffer and valid/ready input.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned SLOT = DEF_SLOT
) (
  input  logic          i2s_clk,
  input  logic          rst,
  input  logic          ws_align,
  input  logic [DW-1:0] din_l,
  input  logic [DW-1:0] din_r,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          i2s_ws,
  output logic          i2s_dout,
  output logic          frame_start,
  output logic          underrun
);

  localparam int unsigned FRAME = 2 * SLOT;
  localparam int unsigned CW    = $clog2(FRAME);
  localparam int unsigned SW    = 2 * DW;

  if (DW > SLOT) begin : g_bad_width
    $error("i2s_tx: DW must not exceed SLOT");
  end

  logic [CW-1:0] cnt;
  logic          wrap_c;
  logic [SW-1:0] shift;
  logic [DW-1:0] hold_l;
  logic [DW-1:0] hold_r;
  logic          hold_full;
  logic          lj_q;
  logic          first;

  logic          load_c;
  logic [CW-1:0] cnt_nxt_c;
  logic [CW-1:0] pos_c;
  logic [SW-1:0] src_c;
  logic [SW-1:0] shift_nxt_c;
  logic          lj_c;

  i2s_frame_ctr #(.SLOT(SLOT)) u_frame_ctr (
    .clk    (i2s_clk),
    .rst    (rst),
    .cnt    (cnt),
    .wrap_c (wrap_c),
    .ws     (i2s_ws)
  );

  assign din_ready = ~hold_full;

  // Left-justified bit for the coming cycle; pad positions beyond DW send 0 without shifting
  always_comb begin
    load_c      = first | wrap_c;
    cnt_nxt_c   = wrap_c ? '0 : cnt + CW'(1);
    pos_c       = (cnt_nxt_c >= CW'(SLOT)) ? cnt_nxt_c - CW'(SLOT) : cnt_nxt_c;
    src_c       = shift;
    if (load_c) begin
      src_c = hold_full ? {hold_l, hold_r} : '0;
    end
    lj_c        = 1'b0;
    shift_nxt_c = src_c;
    if (pos_c < CW'(DW)) begin
      lj_c        = src_c[SW-1];
      shift_nxt_c = src_c << 1;
    end
  end

  // A write on a load edge lands after the load, so it is held for the following frame
  always_ff @(posedge i2s_clk) begin
    if (rst) begin
      shift       <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
      lj_q        <= 1'b0;
      i2s_dout    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      first       <= 1'b1;
    end else begin
      first       <= 1'b0;
      shift       <= shift_nxt_c;
      lj_q        <= lj_c;
      i2s_dout    <= (ws_align == ALIGN_LJ) ? lj_c : lj_q;
      frame_start <= load_c & hold_full;
      underrun    <= load_c & ~hold_full;
      if (load_c) begin
        hold_full <= 1'b0;
      end
      if (din_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_l    <= din_l;
        hold_r    <= din_r;
      end
    end
  end

endmodule
